imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, output immediate width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 8, width of sideband tag carried alongside each instruction.
REQ-003 Parameter ZIMM_EN, default 1, enables the CSR zimm (Z) format decode.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 flush  input  1  synchronous discard of all buffered entries.
REQ-007 in_valid  input  1  in_inst/in_tag present.
REQ-008 in_ready  output  1  block can accept an entry this cycle.
REQ-009 in_inst  input  32  raw RV32 instruction word.
REQ-010 in_tag  input  TAG_W  opaque sideband, returned unchanged.
REQ-011 out_valid  output  1  output entry present.
REQ-012 out_ready  input  1  consumer accepts the output entry.
REQ-013 out_imm  output  XLEN  decoded, extended immediate.
REQ-014 out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, Z=6, ILL=7.
REQ-015 out_illegal  output  1  opcode not recognised.
REQ-016 out_tag  output  TAG_W  tag of the output entry.

Function
REQ-017 Format by opcode in_inst[6:0]: 0010011/0000011/1100111/0001111 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011 -> R; 1110011 -> Z when ZIMM_EN=1 and inst[14]=1, else I; any other opcode -> ILL.
REQ-018 Immediates: I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],0}); U = sext({inst[31:12],12'b0}); J = sext({inst[31],inst[19:12],inst[20],inst[30:21],0}); Z = zext(inst[19:15]); R and ILL = 0.
REQ-019 Sign extension replicates inst[31] up to bit XLEN-1; for XLEN=64, U values are sign-extended.
REQ-020 out_illegal = 1 exactly when out_fmt = ILL.
REQ-021 Decode occurs at acceptance; each entry is stored in a 2-entry in-order FIFO as {imm, fmt, illegal, tag}.
REQ-022 Accept when in_valid & in_ready; pop when out_valid & out_ready.
REQ-023 Latency: an entry accepted at edge k is presented with out_valid=1 in the cycle after edge k, provided the FIFO was empty.
REQ-024 in_ready = (count < 2), driven from registered state only; there is no combinational path from out_ready to in_ready.
REQ-025 out_valid = (count != 0); out_* reflect the head entry and hold stable while out_valid & !out_ready.
REQ-026 A simultaneous push and pop with count=1 leaves count=1 and advances the head.
REQ-027 When count=2, no push occurs in that cycle regardless of pop.
REQ-028 Read/write pointers are 1 bit each and wrap modulo 2; count ranges from 0 to 2.
REQ-029 flush=1 sets count and pointers to 0 at the next edge; it has priority over simultaneous push and pop, and the entry offered in that cycle is dropped.

Reset
REQ-030 While rst_n=0 at an edge: count=0, pointers=0, out_valid=0, in_ready=1 after the edge, and stored entries are zeroed (out_imm=0, out_fmt=0, out_illegal=0, out_tag=0).
REQ-031 Reset asserted mid-operation discards all entries and has priority over flush, push and pop.

Structure
REQ-032 Shared package imm_pkg holds the fmt codes (R..ILL) and the opcode constants.
REQ-033 Combinational sub-module imm_decode (inst, ZIMM_EN, XLEN -> imm, fmt, illegal) feeds the FIFO write port.

Verification
REQ-034 XLEN=32, in_inst 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=0xFFFFFFFF, out_fmt=1, out_valid=1 for one cycle.
REQ-035 In_inst 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC, out_fmt=3; in_inst 0x300FD073 (csrrwi zimm 31) -> out_imm=0x1F, out_fmt=6.
REQ-036 XLEN=64, in_inst 0x800002B7 (lui x5,0x80000) -> out_imm=0xFFFFFFFF80000000, out_fmt=4.
REQ-037 out_ready=0, offer tags 1, 2, 3 back-to-back -> in_ready drops after two accepts and tag 3 is held; raise out_ready -> tags emerge in order 1, 2, 3 and outputs stay stable while stalled.
REQ-038 count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, count=0, in_ready=1, and the offered entry is never output.
REQ-039 In_inst 0x0000007F -> out_illegal=1, out_fmt=7, out_imm=0; reset asserted with count=2 -> out_valid=0 the next cycle.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: format codes and RV32 opcodes.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32 immediate decode: classifies the format and builds the
// XLEN-wide extended immediate.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ZIMM_EN = 1
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  fmt_e        f;
  logic [31:0] imm32;

  always_comb begin
    f = FMT_ILL;
    unique case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_FENCE: f = FMT_I;
      OP_STORE:                           f = FMT_S;
      OP_BRANCH:                          f = FMT_B;
      OP_LUI, OP_AUIPC:                   f = FMT_U;
      OP_JAL:                             f = FMT_J;
      OP_OP:                              f = FMT_R;
      OP_SYSTEM: f = ((ZIMM_EN != 0) && inst[14]) ? FMT_Z : FMT_I;
      default:                            f = FMT_ILL;
    endcase
  end

  // Every 32-bit form carries its sign in bit 31 (Z and R/ILL have it clear),
  // so widening to XLEN is a single replication of imm32[31].
  always_comb begin
    imm32 = '0;
    unique case (f)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_Z:   imm32 = {27'b0, inst[19:15]};
      default: imm32 = '0;
    endcase
    imm        = {XLEN{imm32[31]}};
    imm[31:0]  = imm32;
    fmt        = f;
    illegal    = (f == FMT_ILL);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator: decodes on acceptance and buffers results in a
// 2-entry in-order FIFO with valid/ready handshakes on both sides.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 8,
  parameter int ZIMM_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  entry_t     mem [2];
  logic       wptr, rptr;
  logic [1:0] cnt;
  logic       push, pop;

  imm_decode #(.XLEN(XLEN), .ZIMM_EN(ZIMM_EN)) u_dec (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  // Ready depends only on the registered count, never on out_ready.
  assign in_ready  = (cnt < 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      cnt  <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= '{imm: dec_imm, fmt: dec_fmt, ill: dec_ill, tag: in_tag};
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  assign out_imm     = mem[rptr].imm;
  assign out_fmt     = mem[rptr].fmt;
  assign out_illegal = mem[rptr].ill;
  assign out_tag     = mem[rptr].tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode vectors on XLEN=32 and XLEN=64
// instances side by side, plus handshake, flush and reset sequences.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [7:0]  in_tag;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm;
  logic [2:0]  a_out_fmt;
  logic [7:0]  a_out_tag;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [7:0]  b_out_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .ZIMM_EN(1)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal), .out_tag(a_out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .ZIMM_EN(1)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .out_tag(b_out_tag)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  fmt;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Both instances share inputs, so state checks apply to both.
  task automatic chk_state(input string name, input logic vld, input logic rdy);
    chk({name, " vld32"}, a_out_valid, vld);
    chk({name, " vld64"}, b_out_valid, vld);
    chk({name, " rdy32"}, a_in_ready, rdy);
    chk({name, " rdy64"}, b_in_ready, rdy);
  endtask

  task automatic chk_tag(input string name, input logic [7:0] t);
    chk({name, " tag32"}, a_out_tag, t);
    chk({name, " tag64"}, b_out_tag, t);
  endtask

  initial begin
    vec_t v [14];
    v[0]  = '{32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 3'd1, "addi-1"};
    v[1]  = '{32'hFE000EE3, 64'hFFFFFFFF_FFFFFFFC, 3'd3, "beq-4"};
    v[2]  = '{32'h300FD073, 64'h00000000_0000001F, 3'd6, "csrrwi31"};
    v[3]  = '{32'h800002B7, 64'hFFFFFFFF_80000000, 3'd4, "lui8000"};
    v[4]  = '{32'h0000007F, 64'h0,                 3'd7, "ill7f"};
    v[5]  = '{32'h00B50533, 64'h0,                 3'd0, "add"};
    v[6]  = '{32'hFE512C23, 64'hFFFFFFFF_FFFFFFF8, 3'd2, "sw-8"};
    v[7]  = '{32'h0080006F, 64'h00000000_00000008, 3'd5, "jal+8"};
    v[8]  = '{32'hFFDFF0EF, 64'hFFFFFFFF_FFFFFFFC, 3'd5, "jal-4"};
    v[9]  = '{32'h30001073, 64'h00000000_00000300, 3'd1, "csrrw"};
    v[10] = '{32'hFFFFF073, 64'h00000000_0000001F, 3'd6, "csrrci-zext"};
    v[11] = '{32'h7FF02083, 64'h00000000_000007FF, 3'd1, "lw2047"};
    v[12] = '{32'h12345097, 64'h00000000_12345000, 3'd4, "auipc"};
    v[13] = '{32'hFFFFFF80, 64'h0,                 3'd7, "op0"};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_tag = 8'h0;
    tick;
    tick;
    chk_state("reset", 1'b0, 1'b1);
    chk("reset imm64", b_out_imm, 64'h0);
    chk("reset fmt", {61'b0, a_out_fmt}, 64'h0);
    chk("reset ill", {63'b0, a_out_illegal}, 64'h0);
    chk_tag("reset", 8'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_inst = v[i].inst; in_tag = 8'(i + 8'h10);
      tick;
      in_valid = 1'b0;
      chk_state(v[i].name, 1'b1, 1'b1);
      chk({v[i].name, " imm32"}, {32'b0, a_out_imm}, {32'b0, v[i].imm[31:0]});
      chk({v[i].name, " imm64"}, b_out_imm, v[i].imm);
      chk({v[i].name, " fmt32"}, {61'b0, a_out_fmt}, {61'b0, v[i].fmt});
      chk({v[i].name, " fmt64"}, {61'b0, b_out_fmt}, {61'b0, v[i].fmt});
      chk({v[i].name, " ill"}, {63'b0, a_out_illegal}, {63'b0, v[i].fmt == 3'd7});
      chk_tag(v[i].name, 8'(i + 8'h10));
      tick;
      chk_state({v[i].name, " drained"}, 1'b0, 1'b1);
    end

    // Stall: tags 1,2,3 offered back-to-back with the consumer blocked.
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF00093;
    in_tag = 8'd1; tick;
    chk_state("stall1", 1'b1, 1'b1);
    chk_tag("stall1", 8'd1);
    in_tag = 8'd2; tick;
    chk_state("stall2", 1'b1, 1'b0);
    chk_tag("stall2", 8'd1);
    in_tag = 8'd3; tick;
    chk_state("stall3", 1'b1, 1'b0);
    chk_tag("stall3", 8'd1);
    chk("stall3 imm", {32'b0, a_out_imm}, 64'hFFFFFFFF);
    tick;
    chk_tag("stall4", 8'd1);
    out_ready = 1'b1; tick;
    chk_state("release1", 1'b1, 1'b1);
    chk_tag("release1", 8'd2);
    tick;
    in_valid = 1'b0;
    chk_state("release2", 1'b1, 1'b1);
    chk_tag("release2", 8'd3);
    tick;
    chk_state("release3", 1'b0, 1'b1);

    // Flush while full, with a new entry offered in the same cycle.
    out_ready = 1'b0; in_valid = 1'b1;
    in_tag = 8'h41; tick;
    in_tag = 8'h42; tick;
    chk_state("full", 1'b1, 1'b0);
    flush = 1'b1; in_tag = 8'h55; tick;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk_state("flush", 1'b0, 1'b1);
    tick;
    chk_state("flush idle", 1'b0, 1'b1);
    in_valid = 1'b1; in_inst = 32'hFE000EE3; in_tag = 8'h66; tick;
    in_valid = 1'b0;
    chk_state("post-flush", 1'b1, 1'b1);
    chk_tag("post-flush", 8'h66);
    chk("post-flush imm", {32'b0, a_out_imm}, 64'hFFFFFFFC);
    tick;

    // Reset with the FIFO full and traffic pending.
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0000007F;
    in_tag = 8'h71; tick;
    in_tag = 8'h72; tick;
    chk_state("full2", 1'b1, 1'b0);
    chk("full2 ill", {63'b0, a_out_illegal}, 64'h1);
    rst_n = 1'b0; flush = 1'b1; out_ready = 1'b1; tick;
    chk_state("midreset", 1'b0, 1'b1);
    chk_tag("midreset", 8'h0);
    chk("midreset ill", {63'b0, a_out_illegal}, 64'h0);
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    tick;
    chk_state("after reset", 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
